// File: rtl/ysyx_22041405_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041405_ifu
// Brief    : Instruction fetch unit. It owns the PC, keeps at most one memory
//            request in flight and hands {instr, pc} to decode over a
//            valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22041405_ifu #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(32'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,

    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,

    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc
);

    localparam logic [1:0]       c_ST_REQ  = 2'd0;
    localparam logic [1:0]       c_ST_WAIT = 2'd1;
    localparam logic [1:0]       c_ST_HOLD = 2'd2;
    localparam logic [WIDTH-1:0] c_NOP     = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] c_ALIGN   = WIDTH'(3);
    localparam logic [WIDTH-1:0] c_STEP    = WIDTH'(4);

    logic [1:0]       r_state_q, w_state_d;
    logic [WIDTH-1:0] r_pc_q,    w_pc_d;
    logic             r_kill_q,  w_kill_d;
    logic [WIDTH-1:0] r_instr_q, w_instr_d;
    logic [WIDTH-1:0] r_id_pc_q, w_id_pc_d;

    logic [WIDTH-1:0] w_redirect_pc;
    logic             w_consume;

    assign w_redirect_pc = redirect_pc & ~c_ALIGN;
    assign w_consume     = (r_state_q == c_ST_HOLD) && id_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_kill_d  = r_kill_q;
        w_instr_d = r_instr_q;
        w_id_pc_d = r_id_pc_q;

        case (r_state_q)
            c_ST_REQ: begin
                if (imem_req_ready) begin
                    w_state_d = c_ST_WAIT;
                    // The request for the old PC is already gone; its data must be dropped.
                    if (redirect_valid) begin
                        w_kill_d = 1'b1;
                    end
                end
            end
            c_ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill_q || redirect_valid) begin
                        w_kill_d  = 1'b0;
                        w_state_d = c_ST_REQ;
                    end else begin
                        w_instr_d = imem_rsp_data;
                        w_id_pc_d = r_pc_q;
                        w_state_d = c_ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_d = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (redirect_valid) begin
                    w_state_d = c_ST_REQ;
                end else if (w_consume) begin
                    w_pc_d    = r_pc_q + c_STEP;
                    w_state_d = c_ST_REQ;
                end
            end
            default: begin
                w_state_d = c_ST_REQ;
            end
        endcase

        // A redirect always overrides the sequential PC update.
        if (redirect_valid) begin
            w_pc_d = w_redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_REQ;
            r_pc_q    <= RESET_PC;
            r_kill_q  <= 1'b0;
            r_instr_q <= c_NOP;
            r_id_pc_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_kill_q  <= w_kill_d;
            r_instr_q <= w_instr_d;
            r_id_pc_q <= w_id_pc_d;
        end
    end

    assign imem_req_valid = (r_state_q == c_ST_REQ) && !rst;
    assign imem_req_addr  = r_pc_q & ~c_ALIGN;
    assign id_valid       = (r_state_q == c_ST_HOLD);
    assign id_instr       = r_instr_q;
    assign id_pc          = r_id_pc_q;

    // A response can only legally arrive while a request is outstanding.
    a_rsp_only_in_wait : assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (r_state_q == c_ST_WAIT)
    );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041405_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041405_ifu
// Brief    : Self-checking bench for the fetch unit with a latency-configurable
//            memory model and an in-order delivery scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22041405_ifu;

    localparam logic [31:0] c_KEY = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int          checks   = 0;
    int          failures = 0;
    int          mem_lat  = 1;
    logic [31:0] exp_q[$];

    ysyx_22041405_ifu #(
        .WIDTH    (32),
        .RESET_PC (32'h8000_0000)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    // Memory: a request accepted in cycle n answers in cycle n+mem_lat with addr^KEY.
    initial begin : p_mem
        logic        m_acc, m_rst, m_pend;
        logic [31:0] m_addr, m_paddr;
        int          m_cnt;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_paddr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            m_acc  = imem_req_valid && imem_req_ready;
            m_addr = imem_req_addr;
            m_rst  = rst;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (m_rst) begin
                m_pend = 1'b0;
            end else begin
                if (m_acc) begin
                    m_pend  = 1'b1;
                    m_cnt   = mem_lat;
                    m_paddr = m_addr;
                end
                if (m_pend) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = m_paddr ^ c_KEY;
                        m_pend = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: every instruction the decoder actually takes must match the next expected PC.
    initial begin : p_sb
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc !== e || id_instr !== (e ^ c_KEY)) begin
                        failures++;
                        $display("FAIL sb_delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                                 id_pc, id_instr, e, e ^ c_KEY);
                    end
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: the first cycle with rst low.
    task automatic do_reset();
        step();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valids: got id_valid=%b req_valid=%b, required 0 0", id_valid, imem_req_valid);
        end
        checks++;
        if (id_instr !== 32'h0000_0013 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got instr=%h pc=%h, required 00000013 00000000", id_instr, id_pc);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic exp_req, exp_idv;
        mem_lat = 1;
        do_reset();
        id_ready = 1'b1;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0004);
        exp_q.push_back(32'h8000_0008);
        for (int c = 0; c < 9; c++) begin
            exp_req = (c % 3 == 0);
            exp_idv = (c % 3 == 2);
            @(negedge clk);
            checks++;
            if (imem_req_valid !== exp_req || id_valid !== exp_idv) begin
                failures++;
                $display("FAIL stream_valids c=%0d: got req=%b idv=%b, required req=%b idv=%b",
                         c, imem_req_valid, id_valid, exp_req, exp_idv);
            end
            if (exp_req) begin
                checks++;
                if (imem_req_addr !== 32'h8000_0000 + 32'(4 * (c / 3))) begin
                    failures++;
                    $display("FAIL stream_addr c=%0d: got %h, required %h",
                             c, imem_req_addr, 32'h8000_0000 + 32'(4 * (c / 3)));
                end
            end
            step();
        end
        id_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        step();
        step();
        exp_q.push_back(32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || imem_req_valid !== 1'b0 || id_pc !== 32'h8000_0000 ||
                id_instr !== (32'h8000_0000 ^ c_KEY)) begin
                failures++;
                $display("FAIL bp_hold i=%0d: got idv=%b req=%b pc=%h instr=%h, required 1 0 80000000 %h",
                         i, id_valid, imem_req_valid, id_pc, id_instr, 32'h8000_0000 ^ c_KEY);
            end
            step();
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
            failures++;
            $display("FAIL bp_next_req: got valid=%b addr=%h, required 1 80000004", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 2;
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_stale: got idv=%b req=%b, required 0 0", id_valid, imem_req_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            failures++;
            $display("FAIL rw_req: got idv=%b req=%b addr=%h, required 0 1 80000100",
                     id_valid, imem_req_valid, imem_req_addr);
        end
        step();
        step();
        step();
        exp_q.push_back(32'h8000_0100);
        id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8000_0100) begin
            failures++;
            $display("FAIL rw_deliver: got idv=%b pc=%h, required 1 80000100", id_valid, id_pc);
        end
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        mem_lat = 1;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        id_ready       = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1) begin
            failures++;
            $display("FAIL rh_in_hold: got idv=%b, required 1", id_valid);
        end
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
            failures++;
            $display("FAIL rh_drop: got idv=%b req=%b addr=%h, required 0 1 80000200",
                     id_valid, imem_req_valid, imem_req_addr);
        end
        step();
        step();
        exp_q.push_back(32'h8000_0200);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_req();
        mem_lat = 1;
        do_reset();
        imem_req_ready = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL rq_stable: got req=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr);
        end
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
            failures++;
            $display("FAIL rq_switch: got req=%b addr=%h, required 1 80000300", imem_req_valid, imem_req_addr);
        end
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rq_kill_wait: got idv=%b req=%b, required 0 0", id_valid, imem_req_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin
            failures++;
            $display("FAIL rq_refetch: got idv=%b req=%b addr=%h, required 0 1 80000400",
                     id_valid, imem_req_valid, imem_req_addr);
        end
        step();
        step();
        exp_q.push_back(32'h8000_0400);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_wrap_and_midreset();
        mem_lat = 2;
        do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_top: got req=%b addr=%h, required 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        step();
        step();
        step();
        step();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_zero: got req=%b addr=%h, required 1 00000000", imem_req_valid, imem_req_addr);
        end
        step();
        rst      = 1'b1;
        id_ready = 1'b0;
        mem_lat  = 1;
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0000_0013) begin
            failures++;
            $display("FAIL midrst_vals: got idv=%b req=%b pc=%h instr=%h, required 0 0 00000000 00000013",
                     id_valid, imem_req_valid, id_pc, id_instr);
        end
        step();
        rst      = 1'b0;
        id_ready = 1'b1;
        exp_q.push_back(32'h8000_0000);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL midrst_restart: got req=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr);
        end
        step();
        step();
        step();
        id_ready = 1'b0;
    endtask

    initial begin : p_main
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_wrap_and_midreset();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d undelivered, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
